// File: rtl/adv_cfg_seq.sv
// adv_cfg_seq: ADV7511 HDMI transmitter register-configuration sequencer.
//
// After reset (and, when built with ADV_CFG_HPD_EN, after a debounced hot-plug
// rise), waits a power-up delay and then walks a fixed 14-entry (reg, value)
// table. It issues one write at a time to a byte-level I2C master through a
// req/done handshake. A NACKed write is retried after a back-off delay, up to
// MAX_RETRIES times, before the sequencer parks in an error state. The table
// sets the transmitter up for 12-bit DDR, 24-bpp RGB input.
//
// Optional feature macro: ADV_CFG_HPD_EN (hpd synchronised, debounced, and a
// stable rise re-runs the table from DONE or FAIL).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   hpd        in   hot-plug detect, asynchronous (used only with ADV_CFG_HPD_EN)
//   i2c_req    out  held high while a write is pending
//   i2c_dev    out  7-bit device address (DEV_ADDR)
//   i2c_reg    out  register address of the current entry
//   i2c_wdata  out  data byte of the current entry
//   i2c_done   in   one-cycle pulse: transfer complete with ACK
//   i2c_nack   in   one-cycle pulse: transfer complete with NACK
//   cfg_busy   out  table in progress
//   cfg_done   out  table completed without error
//   cfg_error  out  retries exhausted (sticky until reset or re-init)
//   cfg_index  out  current table index
module adv_cfg_seq #(
    parameter logic [6:0]  DEV_ADDR     = 7'h39,
    parameter logic [23:0] PWRUP_DELAY  = 24'd2000000,
    parameter logic [15:0] RETRY_DELAY  = 16'd50000,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter logic [19:0] HPD_DEBOUNCE = 20'd500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hpd,
    output logic       i2c_req,
    output logic [6:0] i2c_dev,
    output logic [7:0] i2c_reg,
    output logic [7:0] i2c_wdata,
    input  logic       i2c_done,
    input  logic       i2c_nack,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_error,
    output logic [4:0] cfg_index
);

    localparam logic [4:0]  LastIdx = 5'd13;
    localparam int unsigned RetryW  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StPwrup,
        StIssue,
        StWait,
        StBackoff,
        StDone,
        StFail
    } state_e;

    state_e            state_q, state_d;
    logic [23:0]       cnt_q, cnt_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [4:0]        index_q, index_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              req_q, busy_q, done_q, error_q;
    logic [15:0]       tbl_entry;
    logic              hpd_rerun;

    // Configuration table: {register, value}.
    always_comb begin
        case (index_q)
            5'd0:    tbl_entry = 16'h41_10;
            5'd1:    tbl_entry = 16'h98_03;
            5'd2:    tbl_entry = 16'h9A_E0;
            5'd3:    tbl_entry = 16'h9C_30;
            5'd4:    tbl_entry = 16'h9D_61;
            5'd5:    tbl_entry = 16'hA2_A4;
            5'd6:    tbl_entry = 16'hA3_A4;
            5'd7:    tbl_entry = 16'hE0_D0;
            5'd8:    tbl_entry = 16'hF9_00;
            5'd9:    tbl_entry = 16'h15_05;
            5'd10:   tbl_entry = 16'h16_00;
            5'd11:   tbl_entry = 16'h48_00;
            5'd12:   tbl_entry = 16'hBA_60;
            5'd13:   tbl_entry = 16'hAF_06;
            default: tbl_entry = 16'h00_00;
        endcase
    end

`ifdef ADV_CFG_HPD_EN
    logic        hpd_meta_q, hpd_sync_q;
    logic        hpd_deb_q, hpd_deb_d;
    logic [19:0] deb_cnt_q, deb_cnt_d;
    logic        hpd_pend_q, hpd_pend_d;
    logic        hpd_rise;
    logic        in_idle;

    // Debounced level only goes high after HPD_DEBOUNCE consecutive high cycles;
    // any low sample drops it at once (falls are ignored by the sequencer).
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        hpd_deb_d = hpd_deb_q;
        if (!hpd_sync_q) begin
            deb_cnt_d = 20'd0;
            hpd_deb_d = 1'b0;
        end else if (deb_cnt_q == HPD_DEBOUNCE) begin
            hpd_deb_d = 1'b1;
        end else begin
            deb_cnt_d = deb_cnt_q + 20'd1;
        end
    end

    assign hpd_rise  = hpd_deb_d & ~hpd_deb_q;
    assign in_idle   = (state_q == StDone) || (state_q == StFail);
    assign hpd_rerun = hpd_pend_q | hpd_rise;
    // A rise seen while busy is held until the table finishes.
    assign hpd_pend_d = (hpd_pend_q | hpd_rise) & ~in_idle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hpd_meta_q <= 1'b0;
            hpd_sync_q <= 1'b0;
            hpd_deb_q  <= 1'b0;
            deb_cnt_q  <= 20'd0;
            hpd_pend_q <= 1'b0;
        end else begin
            hpd_meta_q <= hpd;
            hpd_sync_q <= hpd_meta_q;
            hpd_deb_q  <= hpd_deb_d;
            deb_cnt_q  <= deb_cnt_d;
            hpd_pend_q <= hpd_pend_d;
        end
    end
`else
    logic unused_hpd;
    assign unused_hpd = hpd;
    assign hpd_rerun  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        index_d = index_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        case (state_q)
            StPwrup: begin
                if (cnt_q == 24'd0) begin
                    index_d = 5'd0;
                    state_d = StIssue;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            StIssue: begin
                reg_d   = tbl_entry[15:8];
                wdata_d = tbl_entry[7:0];
                state_d = StWait;
            end
            StWait: begin
                // NACK wins when both pulses arrive together.
                if (i2c_nack) begin
                    if (retry_q == MaxRetry) begin
                        state_d = StFail;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        cnt_d   = {8'd0, RETRY_DELAY};
                        state_d = StBackoff;
                    end
                end else if (i2c_done) begin
                    retry_d = '0;
                    if (index_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        index_d = index_q + 5'd1;
                        state_d = StIssue;
                    end
                end
            end
            StBackoff: begin
                if (cnt_q == 24'd0) begin
                    state_d = StIssue;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            StDone, StFail: begin
                if (hpd_rerun) begin
                    retry_d = '0;
                    cnt_d   = PWRUP_DELAY;
                    state_d = StPwrup;
                end
            end
            default: begin
                state_d = StPwrup;
                cnt_d   = PWRUP_DELAY;
            end
        endcase
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as the state and read zero during reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StPwrup;
            cnt_q   <= PWRUP_DELAY;
            retry_q <= '0;
            index_q <= 5'd0;
            reg_q   <= 8'd0;
            wdata_q <= 8'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            index_q <= index_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            req_q   <= (state_d == StWait);
            busy_q  <= (state_d == StPwrup) || (state_d == StIssue) ||
                       (state_d == StWait) || (state_d == StBackoff);
            done_q  <= (state_d == StDone);
            error_q <= (state_d == StFail);
        end
    end

    assign i2c_req   = req_q;
    assign i2c_dev   = DEV_ADDR;
    assign i2c_reg   = reg_q;
    assign i2c_wdata = wdata_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_error = error_q;
    assign cfg_index = index_q;

endmodule

// File: tb/tb_adv_cfg_seq.sv
// Bench for adv_cfg_seq: a scoreboard of expected I2C writes built from the
// table and NACK plan, an I2C responder, and a monitor that pops and checks on
// every i2c_req rise (address, data, handshake latency).
module tb_adv_cfg_seq;

    localparam int PD  = 10;
    localparam int RD  = 4;
    localparam int MR  = 3;
    localparam int DEB = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       hpd = 1'b0;
    logic       rsp_done = 1'b0, rsp_nack = 1'b0;
    logic       stray_done = 1'b0, stray_nack = 1'b0;
    logic       i2c_done, i2c_nack;
    logic       i2c_req, cfg_busy, cfg_done, cfg_error;
    logic [6:0] i2c_dev;
    logic [7:0] i2c_reg, i2c_wdata;
    logic [4:0] cfg_index;

    assign i2c_done = rsp_done | stray_done;
    assign i2c_nack = rsp_nack | stray_nack;

    always #5 clk = ~clk;

    adv_cfg_seq #(
        .DEV_ADDR    (7'h39),
        .PWRUP_DELAY (24'(PD)),
        .RETRY_DELAY (16'(RD)),
        .MAX_RETRIES (MR),
        .HPD_DEBOUNCE(20'(DEB))
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .hpd      (hpd),
        .i2c_req  (i2c_req),
        .i2c_dev  (i2c_dev),
        .i2c_reg  (i2c_reg),
        .i2c_wdata(i2c_wdata),
        .i2c_done (i2c_done),
        .i2c_nack (i2c_nack),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_error(cfg_error),
        .cfg_index(cfg_index)
    );

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] d;
    } wr_t;

    logic [15:0] tbl [14] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
                              16'hA3A4, 16'hE0D0, 16'hF900, 16'h1505, 16'h1600, 16'h4800,
                              16'hBA60, 16'hAF06};

    wr_t exp_q[$];
    int  nack_plan [14];
    int  both_entry = -1;
    int  rsp_delay = 3;
    int  att [14];
    int  cyc = 0;
    int  last_resp_cyc = 0;
    bit  last_resp_nack = 0;
    int  n_rise = 0;
    int  exp_fail = -1;
    int  n_cmp = 0;
    int  n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle_counter();
        forever begin
            @(posedge clk);
            cyc = reset_n ? cyc + 1 : 0;
        end
    endtask

    task automatic monitor();
        bit  prev = 0, first = 1, skip = 0, bprev = 0;
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                prev = 0; first = 1; skip = 0; bprev = 0;
            end else begin
                // Re-run without reset: no fixed reference for the first request.
                if (cfg_busy && !bprev && !first) skip = 1;
                bprev = cfg_busy;
                if (i2c_req && !prev) begin
                    n_rise++;
                    check("i2c_dev", 32'(i2c_dev), 32'h39);
                    check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        check("i2c_reg", 32'(i2c_reg), 32'(w.r));
                        check("i2c_wdata", 32'(i2c_wdata), 32'(w.d));
                    end
                    if (first)
                        check("pwrup_latency", 32'(cyc), 32'(PD + 2));
                    else if (!skip)
                        check("req_latency", 32'(cyc - last_resp_cyc),
                              32'(last_resp_nack ? RD + 3 : 2));
                    first = 0;
                    skip  = 0;
                end
                prev = i2c_req;
            end
        end
    endtask

    task automatic responder();
        bit prev = 0, abort, is_nack, both;
        int e, nacks, k;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                for (int i = 0; i < 14; i++) att[i] = 0;
                prev = 0;
            end else begin
                if (i2c_req && !prev) begin
                    e = int'(cfg_index);
                    abort = 0;
                    k = 1;
                    while (k < rsp_delay && !abort) begin
                        @(posedge clk);
                        #2;
                        if (!reset_n) abort = 1;
                        k++;
                    end
                    if (!abort && e < 14) begin
                        nacks   = nack_plan[e] + ((e == both_entry) ? 1 : 0);
                        both    = (e == both_entry) && (att[e] == 0);
                        is_nack = att[e] < nacks;
                        rsp_nack = is_nack;
                        rsp_done = both || !is_nack;
                        last_resp_cyc  = cyc;
                        last_resp_nack = is_nack;
                        att[e]++;
                        @(posedge clk);
                        #2;
                        rsp_done = 0;
                        rsp_nack = 0;
                    end
                    if (abort)
                        for (int i = 0; i < 14; i++) att[i] = 0;
                end
                prev = i2c_req;
            end
        end
    endtask

    task automatic check_reset_state();
        check("rst_i2c_req", 32'(i2c_req), 0);
        check("rst_i2c_reg", 32'(i2c_reg), 0);
        check("rst_i2c_wdata", 32'(i2c_wdata), 0);
        check("rst_cfg_busy", 32'(cfg_busy), 0);
        check("rst_cfg_done", 32'(cfg_done), 0);
        check("rst_cfg_error", 32'(cfg_error), 0);
        check("rst_cfg_index", 32'(cfg_index), 0);
    endtask

    // Expected attempts per entry: one per NACK plus the final one, capped at
    // MAX_RETRIES+1; an entry with more NACKs than that ends the run in error.
    task automatic start_scenario();
        int n, tries;
        exp_q.delete();
        exp_fail = -1;
        for (int e = 0; e < 14; e++) begin
            n = nack_plan[e] + ((e == both_entry) ? 1 : 0);
            tries = (n > MR) ? MR + 1 : n + 1;
            for (int t = 0; t < tries; t++) exp_q.push_back(wr_t'(tbl[e]));
            if (n > MR) begin
                exp_fail = e;
                break;
            end
        end
        @(posedge clk);
        #3;
        reset_n = 0;
        #1;
        check_reset_state();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task automatic finish_scenario();
        int k = 0;
        while (!(cfg_done || cfg_error) && k < 3000) begin
            @(posedge clk);
            #3;
            k++;
        end
        check("finish_in_time", 32'(k < 3000), 1);
        repeat (3) @(posedge clk);
        #3;
        check("end_cfg_done", 32'(cfg_done), 32'(exp_fail < 0));
        check("end_cfg_error", 32'(cfg_error), 32'(exp_fail >= 0));
        check("end_cfg_busy", 32'(cfg_busy), 0);
        check("end_i2c_req", 32'(i2c_req), 0);
        check("end_cfg_index", 32'(cfg_index), 32'((exp_fail >= 0) ? exp_fail : 13));
        check("end_leftover_writes", 32'(exp_q.size()), 0);
    endtask

    task automatic clear_plan();
        for (int e = 0; e < 14; e++) nack_plan[e] = 0;
        both_entry = -1;
        rsp_delay  = 3;
    endtask

    initial begin
        int base, k;
        fork
            cycle_counter();
            monitor();
            responder();
        join_none

        // Straight run, every write ACKed.
        clear_plan();
        start_scenario();
        finish_scenario();

        // Entry 4 NACKed twice then ACKed.
        clear_plan();
        nack_plan[4] = 2;
        start_scenario();
        finish_scenario();

        // Entry 0 NACKed forever.
        clear_plan();
        nack_plan[0] = 100;
        start_scenario();
        finish_scenario();

        // Reset while waiting on entry 7, then a full rerun.
        clear_plan();
        start_scenario();
        base = n_rise;
        k = 0;
        while (n_rise < base + 8 && k < 1000) begin
            @(posedge clk);
            #3;
            k++;
        end
        check("reach_entry7", 32'(n_rise - base), 8);
        check("entry7_req_high", 32'(i2c_req), 1);
        #1;
        reset_n = 0;
        #1;
        check_reset_state();
        check("unissued_after_reset", 32'(exp_q.size()), 6);
        start_scenario();
        finish_scenario();

        // Stray done in PWRUP, done+nack together on entry 2, strays in DONE.
        clear_plan();
        both_entry = 2;
        start_scenario();
        repeat (3) @(posedge clk);
        #3;
        stray_done = 1;
        @(posedge clk);
        #3;
        stray_done = 0;
        finish_scenario();
        stray_done = 1;
        stray_nack = 1;
        @(posedge clk);
        #3;
        stray_done = 0;
        stray_nack = 0;
        repeat (5) @(posedge clk);
        #3;
        check("done_after_stray", 32'(cfg_done), 1);
        check("idle_req_after_stray", 32'(i2c_req), 0);

        // Randomised NACK plans, responder delays and coincident pulses.
        for (int s = 0; s < 6; s++) begin
            clear_plan();
            rsp_delay = int'($urandom_range(1, 5));
            for (int e = 0; e < 14; e++)
                nack_plan[e] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 2) == 0) nack_plan[$urandom_range(0, 13)] = 4;
            if ($urandom_range(0, 1) == 1) both_entry = int'($urandom_range(0, 13));
            start_scenario();
            finish_scenario();
        end

`ifdef ADV_CFG_HPD_EN
        // Glitch after DONE is ignored; a stable rise reruns the table.
        clear_plan();
        start_scenario();
        finish_scenario();
        hpd = 1;
        repeat (5) @(posedge clk);
        #3;
        hpd = 0;
        repeat (20) @(posedge clk);
        #3;
        check("hpd_glitch_done", 32'(cfg_done), 1);
        check("hpd_glitch_busy", 32'(cfg_busy), 0);
        exp_q.delete();
        for (int e = 0; e < 14; e++) exp_q.push_back(wr_t'(tbl[e]));
        exp_fail = -1;
        hpd = 1;
        k = 0;
        while (cfg_done && k < 100) begin
            @(posedge clk);
            #3;
            k++;
        end
        check("hpd_rise_clears_done", 32'(cfg_done), 0);
        finish_scenario();
        hpd = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
